// File: rtl/negate_arbiter.sv
// negate_arbiter: round-robin front end that shares one two's-complement
// negation datapath among NUM_REQ requesters, with a valid/ready result port.
module negate_arbiter #(
  parameter  int WIDTH   = 4,
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         out_data,
  output logic [IDW-1:0]           out_id,
  output logic                     out_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_reg;
  logic [WIDTH-1:0] op_reg;
  logic             win_vld;
  logic [IDW-1:0]   win_id;
  logic [WIDTH-1:0] win_op;

  // Round-robin pick: first pending request after the last winner.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_vld && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_id  = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign win_op = in_data[int'(win_id)*WIDTH +: WIDTH];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: grant, compute for one cycle, then wait for the consumer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_vld) state_nxt = CALC;
      CALC:    state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture, negate and hold the result; the pointer moves only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack       <= '0;
      op_reg    <= '0;
      id_reg    <= '0;
      out_data  <= '0;
      out_id    <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
      rr_ptr    <= IDW'(NUM_REQ-1);
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            op_reg      <= win_op;
            id_reg      <= win_id;
            ack[win_id] <= 1'b1;
          end
        end
        CALC: begin
          out_data  <= ~op_reg + 1'b1;
          out_id    <= id_reg;
          out_ovf   <= (op_reg == MIN_NEG);
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rr_ptr    <= id_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_negate_arbiter.sv
// tb_negate_arbiter: directed and random stimulus against a cycle model
// derived from the arbitration and negation rules.
module tb_negate_arbiter;

  localparam int W  = 4;
  localparam int NR = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR*W-1:0] in_data = '0;
  logic [NR-1:0]   ack;
  logic [W-1:0]    out_data;
  logic [IW-1:0]   out_id;
  logic            out_ovf;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  negate_arbiter #(.WIDTH(W), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req(req), .in_data(in_data),
    .ack(ack), .out_data(out_data), .out_id(out_id),
    .out_ovf(out_ovf), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // model: phase 0 idle, 1 operand captured, 2 result offered
  int m_phase = 0;
  int m_ptr   = NR-1;
  int m_op    = 0;
  int m_id    = 0;
  int e_ack   = 0;
  int e_valid = 0;
  int e_data  = 0;
  int e_id    = 0;
  int e_ovf   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_ptr = NR-1;
      e_ack = 0; e_valid = 0; e_data = 0; e_id = 0; e_ovf = 0;
    end else begin
      e_ack = 0;
      if (m_phase == 0) begin
        for (int k = 1; k <= NR; k++) begin
          int j;
          j = (m_ptr + k) % NR;
          if (m_phase == 0 && req[j]) begin
            e_ack   = 1 << j;
            m_op    = int'(in_data[j*W +: W]);
            m_id    = j;
            m_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        e_data  = ((1 << W) - m_op) % (1 << W);
        e_id    = m_id;
        e_ovf   = (m_op == (1 << (W-1))) ? 1 : 0;
        e_valid = 1;
        m_phase = 2;
      end else if (out_ready) begin
        e_valid = 0;
        m_ptr   = m_id;
        m_phase = 0;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // every cycle: compare the DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.ack", int'(ack), e_ack);
      chk("m.valid", int'(out_valid), e_valid);
      chk("m.busy", int'(busy), (m_phase != 0) ? 1 : 0);
      if (e_valid != 0) begin
        chk("m.data", int'(out_data), e_data);
        chk("m.id", int'(out_id), e_id);
        chk("m.ovf", int'(out_ovf), e_ovf);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string nm, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (ack == '0 && n < 10);
    if (ack == '0) chk({nm, ".timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int order [5] = '{0, 1, 2, 3, 0};
    // 1 reset / basic
    step();
    step();
    chk_en = 1'b1;
    chk("rst.ack", int'(ack), 0);
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.data", int'(out_data), 0);
    chk("rst.busy", int'(busy), 0);
    rst = 1'b0;
    req = 4'b0001;
    in_data[3:0] = 4'b0011;
    step();
    chk("t1.ack", int'(ack), 4'b0001);
    req = '0;
    step();
    chk("t1.valid", int'(out_valid), 1);
    chk("t1.data", int'(out_data), 4'b1101);
    chk("t1.id", int'(out_id), 0);
    chk("t1.ovf", int'(out_ovf), 0);
    step();
    // 2 sweep on requester 2
    for (int v = 0; v < 16; v++) begin
      req = 4'b0100;
      in_data[11:8] = 4'(v);
      wait_ack("t2", n);
      chk("t2.ack", int'(ack), 4'b0100);
      req = '0;
      step();
      chk("t2.data", int'(out_data), (16 - v) % 16);
      if (v == 8) chk("t2.ovf8", int'(out_ovf), 1);
      if (v == 8) chk("t2.data8", int'(out_data), 4'b1000);
      if (v == 0) chk("t2.data0", int'(out_data), 0);
      if (v == 0) chk("t2.ovf0", int'(out_ovf), 0);
      step();
    end
    // 3 round-robin with all requests held
    do_reset();
    in_data = 16'h4321;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack("t3", n);
      chk("t3.grant", int'(ack), 1 << order[i]);
      if (i > 0) chk("t3.period", n, 3);
    end
    req = '0;
    step();
    chk("t3.id", int'(out_id), 0);
    step();
    // 4 backpressure
    do_reset();
    out_ready = 1'b0;
    req = 4'b0100;
    in_data[11:8] = 4'b1010;
    wait_ack("t4", n);
    chk("t4.ack", int'(ack), 4'b0100);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4.hold", int'(out_data), 4'b0110);
      chk("t4.valid", int'(out_valid), 1);
      chk("t4.noack", int'(ack), 0);
    end
    out_ready = 1'b1;
    step();
    chk("t4.drop", int'(out_valid), 0);
    step();
    chk("t4.reack", int'(ack), 4'b0100);
    req = '0;
    step();
    step();
    // 5 reset in CALC and in HOLD
    req = 4'b0001;
    step();
    chk("t5.ack", int'(ack), 4'b0001);
    req = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5c.valid", int'(out_valid), 0);
    chk("t5c.busy", int'(busy), 0);
    req = 4'b0001;
    out_ready = 1'b0;
    step();
    req = '0;
    step();
    chk("t5.inhold", int'(out_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("t5h.valid", int'(out_valid), 0);
    chk("t5h.ack", int'(ack), 0);
    chk("t5h.busy", int'(busy), 0);
    req = 4'b0010;
    step();
    chk("t5.g1", int'(ack), 4'b0010);
    req = '0;
    step();
    step();
    req = 4'b0001;
    step();
    chk("t5.g0", int'(ack), 4'b0001);
    req = '0;
    step();
    step();
    // random traffic, model checks every cycle
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(3) == 0) begin
          req[i] = 1'b1;
          in_data[i*W +: W] = W'($urandom);
        end
      end
      out_ready = ($urandom_range(3) != 0);
      rst = ($urandom_range(79) == 0);
      step();
    end
    rst = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
